ssl_srcgen: RTL
===============

// Module: ssl_srcgen
// PURPOSE
//  Synthetic 4-channel source generator feeding the ssl localiser din[3:0] bus.
//  Produces one pseudo-random bitstream (LFSR) on channel 0 and delayed copies on
//  channels 1..3, the delays being programmed as dIdA/dIdB/dIdC. ssl recovers the
//  same delay IDs, giving closed-loop self-test on chip and in simulation.
// PARAMETERS
//  NDATA     128      delay window in samples; delays 0..NDATA-1; NDATA_LOG = $clog2(NDATA)
//  LFSR_SEED 16'hACE1 LFSR reset value; 0 is illegal and is replaced by 16'hACE1
// PORTS
//  clk    in  1          system clock, all logic on rising edge
//  erst   in  1          synchronous reset, active-high
//  en     in  1          sample strobe; one new sample per cycle with en=1
//  load   in  1          latch dIdA/dIdB/dIdC and restart the fill phase
//  dIdA   in  NDATA_LOG  requested delay of channel 1 w.r.t. channel 0, in samples
//  dIdB   in  NDATA_LOG  requested delay of channel 2
//  dIdC   in  NDATA_LOG  requested delay of channel 3
//  dout   out 4          sample bus to ssl din: [0] reference, [1..3] delayed copies
//  valid  out 1          1 = every channel carries a history-backed sample
//  busy   out 1          1 = in FILL (history not yet primed)
// BEHAVIOUR
//  Reset (erst=1 at an edge): lfsr<=LFSR_SEED, hist<=0, dA/dB/dC<=0, fill count<=0,
//   state<=IDLE; hence dout=4'b0000, valid=0, busy=0. Overrides load/en that cycle.
//  LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1,
//   fb = l[15]^l[13]^l[12]^l[10]; on en: l <= {l[14:0],fb}; new sample b = fb.
//  History: NDATA-bit shift register; on en: hist <= {hist[NDATA-2:0], b}.
//   hist[0] = newest sample b(n); hist[k] = b(n-k).
//  Outputs (registered state, combinational select): dout[0]=hist[0],
//   dout[1]=hist[dA], dout[2]=hist[dB], dout[3]=hist[dC]; delay 0 gives a copy of ch0.
//   Latency: dout reflects the sample taken at an en edge from the next cycle on.
//   en=0: lfsr, hist, dout, counters all hold.
//  FSM:
//   IDLE: valid=0, busy=0; LFSR and hist still advance on en. load -> latch delays,
//         cnt<=0, go FILL.
//   FILL: busy=1, valid=0; each en: cnt<=cnt+1. Once the NDATA-th en has been
//         counted (cnt reaches NDATA-1 with en) -> RUN. cnt is NDATA_LOG+1 bits wide
//         so it never wraps.
//   RUN:  valid=1, busy=0; steady generation.
//   load in FILL or RUN: re-latch delays, cnt<=0, -> FILL (valid falls next cycle).
//   load and en in one cycle: the sample shifts and the delays latch; that en is
//   not counted, so FILL needs NDATA further en pulses.
//  Delays are sampled only on load. dIdA/B/C changing without load has no effect.
//  The fill phase guarantees hist holds NDATA real samples before valid=1, so no
//  reset-zero bits appear on a valid channel for any delay up to NDATA-1.
//  Reset mid-operation: immediate return to IDLE with the reset values above.
//   Delays are lost and the LFSR sequence restarts from LFSR_SEED.
// TESTING
//  T1 reset: hold erst=1 for 3 clk with en=1, load=1 -> dout=0, valid=0, busy=0,
//     lfsr=16'hACE1 throughout.
//  T2 fill: load with dIdA/B/C=9/6/3, then en every cycle -> busy=1 for exactly 128
//     en pulses, valid rises on the cycle after the 128th; never both valid and busy.
//  T3 delay check: in RUN with 9/6/3 over 1000 samples -> dout[1](n)==dout[0](n-9),
//     dout[2](n)==dout[0](n-6), dout[3](n)==dout[0](n-3); closed loop with ssl
//     reports dIdA=9, dIdB=6, dIdC=3.
//  T4 bounds: delays 0/127/64 -> dout[1]==dout[0] every cycle;
//     dout[2](n)==dout[0](n-127); LFSR period 65535 with no all-zero state.
//  T5 reload and gaps: load 5/5/5 mid-RUN -> valid=0 for next 128 en pulses, then
//     delay 5 on all channels; en low for 7 cycles -> dout and valid frozen.
//  T6 reset mid-FILL (after 40 en) -> IDLE, dout=0; the sequence after re-load
//     bit-matches T2's from its first sample.

Source files
------------

// File: rtl/ssl_srcgen.sv
// ssl_srcgen: synthetic 4-channel source for the ssl localiser.
// A 16-bit Fibonacci LFSR feeds an NDATA-deep history shift register.
// Channel 0 carries the newest sample. Channels 1..3 carry copies of it,
// delayed by the programmed amounts dA/dB/dC.
// Ports:
//   clk            rising-edge clock
//   erst           synchronous active-high reset
//   en             sample strobe (one new sample per enabled cycle)
//   load           latch dIdA/dIdB/dIdC and restart the fill phase
//   dIdA/dIdB/dIdC delay requests for channels 1..3, in samples
//   dout           [0] reference, [1..3] delayed copies
//   valid          every channel carries a history-backed sample
//   busy           history still priming after a load
module ssl_srcgen #(
   parameter int unsigned NDATA     = 128,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                     clk,
   input  logic                     erst,
   input  logic                     en,
   input  logic                     load,
   input  logic [$clog2(NDATA)-1:0] dIdA,
   input  logic [$clog2(NDATA)-1:0] dIdB,
   input  logic [$clog2(NDATA)-1:0] dIdC,
   output logic [3:0]               dout,
   output logic                     valid,
   output logic                     busy
);

   localparam int unsigned NDATA_LOG = $clog2(NDATA);
   localparam int unsigned CNT_W     = NDATA_LOG + 1;
   // An all-zero seed would lock the LFSR, so it falls back to the default.
   localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t               state, state_d;
   logic [15:0]          lfsr, lfsr_d;
   logic [NDATA-1:0]     hist, hist_d;
   logic [NDATA_LOG-1:0] da, db, dc, da_d, db_d, dc_d;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic                 fb;

   // State register
   always_ff @(posedge clk) begin
      if (erst) begin
         state <= IDLE;
         lfsr  <= SEED;
         hist  <= '0;
         da    <= '0;
         db    <= '0;
         dc    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_d;
         lfsr  <= lfsr_d;
         hist  <= hist_d;
         da    <= da_d;
         db    <= db_d;
         dc    <= dc_d;
         cnt   <= cnt_d;
      end
   end

   // Next-state: sample generation, delay latching and fill counting
   always_comb begin
      state_d = state;
      lfsr_d  = lfsr;
      hist_d  = hist;
      da_d    = da;
      db_d    = db;
      dc_d    = dc;
      cnt_d   = cnt;
      fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

      // The generator runs in every state; only the qualification changes.
      if (en) begin
         lfsr_d = {lfsr[14:0], fb};
         hist_d = {hist[NDATA-2:0], fb};
      end

      // A load takes priority over counting, so the en that arrives with it
      // is not counted toward the fill.
      if (load) begin
         da_d    = dIdA;
         db_d    = dIdB;
         dc_d    = dIdC;
         cnt_d   = '0;
         state_d = FILL;
      end else begin
         case (state)
            FILL: begin
               if (en) begin
                  cnt_d = cnt + CNT_W'(1);
                  if (cnt == CNT_W'(NDATA - 1)) begin
                     state_d = RUN;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode from registered state
   assign dout  = {hist[dc], hist[db], hist[da], hist[0]};
   assign valid = (state == RUN);
   assign busy  = (state == FILL);

endmodule
